edge_point_extract: RTL
=======================

EDGE_POINT_EXTRACT -- requirements
Module: edge_point_extract

Interface
REQ-001 SHALL have parameter THRESHOLD, default 128: minimum 8-bit pixel value classed as an edge point.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: point FIFO entries; power of two, 2..256.
REQ-003 SHALL have port Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port nReset  in  1  asynchronous active-low reset.
REQ-005 SHALL have port PixelIn  in  8  edge-magnitude pixel from the Edge stage (PixelOut), one per clock.
REQ-006 SHALL have port FrameIn  in  1  one-cycle pulse coincident with first pixel of a frame.
REQ-007 SHALL have port LineIn  in  1  one-cycle pulse coincident with first pixel of each subsequent line.
REQ-008 SHALL have port PointValid  out  1  FIFO head holds a point.
REQ-009 SHALL have port PointReady  in  1  consumer accepts head point.
REQ-010 SHALL have port PointX  out  8  column of head point.
REQ-011 SHALL have port PointY  out  8  row of head point.
REQ-012 SHALL have port PointFirst  out  1  head point is first point of its frame.
REQ-013 SHALL have port Overflow  out  1  sticky: a point was dropped this frame.

Function
REQ-014 SHALL run FSM IDLE/ACTIVE; IDLE->ACTIVE on FrameIn; no exit except reset; IDLE ignores all pixels.
REQ-015 SHALL assign coordinates per pixel: FrameIn -> x=0,y=0; LineIn without FrameIn -> x=0,y=prev y+1; else x=prev x+1; all 8-bit, wrap 255->0.
REQ-016 SHALL give FrameIn priority when FrameIn and LineIn coincide.
REQ-017 SHALL class a pixel as edge point when ACTIVE (incl. the FrameIn cycle) and PixelIn >= THRESHOLD.
REQ-018 SHALL register {x,y,first} of an edge point in a stage at edge N and write it to FIFO at edge N+1.
REQ-019 SHALL tag first=1 on the first edge point after each FrameIn, else 0.
REQ-020 SHALL present FIFO first-word-fall-through: with FIFO empty, PointValid rises after edge N+1 for pixel sampled at edge N.
REQ-021 SHALL pop head at any rising edge with PointValid=1 and PointReady=1.
REQ-022 SHALL hold PointX/PointY/PointFirst stable while PointValid=1 and PointReady=0.
REQ-023 SHALL, on write with FIFO full and no pop same edge, drop the new point and set Overflow.
REQ-024 SHALL, on write and pop at same edge with FIFO full, perform both without loss.
REQ-025 SHALL clear Overflow on FrameIn (ACTIVE or IDLE), unless a drop occurs at that same edge.
REQ-026 SHALL drive PointX/PointY/PointFirst to 0 when PointValid=0.
REQ-027 SHALL not flush FIFO on FrameIn; points of the previous frame drain in order.

Reset
REQ-028 SHALL, on nReset low, immediately: FSM=IDLE, FIFO empty, stage empty, x=y=0, PointValid=0, PointX=PointY=0, PointFirst=0, Overflow=0.
REQ-029 SHALL discard all buffered points when reset asserts mid-frame; first point after release needs a new FrameIn.

Configuration
REQ-030 SHALL, with macro EPE_POINT_COUNT_EN defined, add port PointCount  out  16: number of points written (not dropped) in the previous frame, updated at each FrameIn, saturating at 65535, reset 0.
REQ-031 SHALL, without EPE_POINT_COUNT_EN, omit PointCount and its counter; all other behaviour identical.

Verification
REQ-032 SHALL check: pixels 200 before any FrameIn -> PointValid stays 0.
REQ-033 SHALL check: FrameIn with PixelIn=128, PointReady=1 -> PointValid=1 two edges later, X=0,Y=0,First=1; pixel 127 -> no point.
REQ-034 SHALL check: 4x3 frame with edge pixel at (3,2), LineIn at row starts -> single point X=3,Y=2,First=1.
REQ-035 SHALL check: PointReady=0, 17 consecutive edge pixels, FIFO_DEPTH=16 -> 16 points held, Overflow=1, points X=0..15 emerge in order once ready; next FrameIn clears Overflow.
REQ-036 SHALL check: nReset low while FIFO holds 5 points -> PointValid=0 and Overflow=0 at once; after release no point until FrameIn.
REQ-037 SHALL check (EPE_POINT_COUNT_EN): frame with 10 edge points then FrameIn -> PointCount=10.

Source files
------------

// File: rtl/edge_point_extract.sv
// Edge-point extractor: tracks (x,y) of each pixel in a frame and queues the
// coordinates of above-threshold pixels in a FWFT FIFO. Optional macro EPE_POINT_COUNT_EN adds PointCount.
module edge_point_extract #(
  parameter int THRESHOLD  = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [7:0] PixelIn,
  input  logic       FrameIn,
  input  logic       LineIn,
  output logic       PointValid,
  input  logic       PointReady,
  output logic [7:0] PointX,
  output logic [7:0] PointY,
  output logic       PointFirst,
  output logic       Overflow
`ifdef EPE_POINT_COUNT_EN
  ,
  output logic [15:0] PointCount
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [8:0] THR9 = 9'(THRESHOLD);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      x_q, y_q, x_d, y_d;
  logic            pend_q, pend_d;
  logic            is_edge, first_now;

  logic            vld_p1_q;
  logic [7:0]      x_p1_q, y_p1_q;
  logic            first_p1_q;

  logic [16:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            full, push, pop, drop;
  logic            ovf_q, ovf_d;
  logic [16:0]     head;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && FrameIn) state_d = ACTIVE;
  end

  // FrameIn outranks LineIn; coordinates wrap naturally at 8 bits.
  always_comb begin
    x_d = x_q + 8'd1;
    y_d = y_q;
    if (FrameIn) begin
      x_d = 8'd0;
      y_d = 8'd0;
    end else if (LineIn) begin
      x_d = 8'd0;
      y_d = y_q + 8'd1;
    end
  end

  assign is_edge   = (state_q == ACTIVE || FrameIn) && ({1'b0, PixelIn} >= THR9);
  assign first_now = FrameIn | pend_q;

  always_comb begin
    pend_d = pend_q;
    if (is_edge)      pend_d = 1'b0;
    else if (FrameIn) pend_d = 1'b1;
  end

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = PointValid & PointReady;
  assign push = vld_p1_q & (~full | pop);
  assign drop = vld_p1_q & full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A drop on the FrameIn edge belongs to the old frame but still flags the new one.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (FrameIn) ovf_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      pend_q   <= 1'b0;
      vld_p1_q <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pend_q   <= pend_d;
      vld_p1_q <= is_edge;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Stage p1 payload and FIFO storage: qualified by vld_p1_q / count_q.
  always_ff @(posedge Clk) begin
    x_p1_q     <= x_d;
    y_p1_q     <= y_d;
    first_p1_q <= first_now;
    if (push) mem_q[wr_q] <= {x_p1_q, y_p1_q, first_p1_q};
  end

  assign head       = mem_q[rd_q];
  assign PointValid = (count_q != '0);
  assign PointX     = PointValid ? head[16:9] : 8'd0;
  assign PointY     = PointValid ? head[8:1]  : 8'd0;
  assign PointFirst = PointValid ? head[0]    : 1'b0;
  assign Overflow   = ovf_q;

`ifdef EPE_POINT_COUNT_EN
  logic [15:0] frm_cnt_q, pcount_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // The write landing on the FrameIn edge is the old frame's last point.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      frm_cnt_q <= '0;
      pcount_q  <= '0;
    end else if (FrameIn) begin
      pcount_q  <= sat_inc(frm_cnt_q, push);
      frm_cnt_q <= '0;
    end else begin
      frm_cnt_q <= sat_inc(frm_cnt_q, push);
    end
  end

  assign PointCount = pcount_q;
`else
  // No per-frame point statistics in this build.
`endif

endmodule
